// File: rtl/pc_stack_sequencer_pkg.sv
// Shared widths, default interrupt vector and FSM/operation encodings for the PC stack sequencer.
package pc_stack_sequencer_pkg;

  localparam int PC_W   = 32;
  localparam int DATA_W = 16;
  localparam int FLAG_W = 4;

  localparam logic [PC_W-1:0] INT_VECTOR_DEFAULT = 32'h0000_0000;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PUSH_HI,
    ST_PUSH_LO,
    ST_PUSH_FLG,
    ST_POP_FLG,
    ST_POP_LO,
    ST_POP_HI,
    ST_WAIT_HI,
    ST_REDIRECT
  } state_t;

  typedef enum logic [1:0] {
    OP_CALL,
    OP_INT,
    OP_RET,
    OP_RTI
  } op_t;

endpackage

// File: rtl/pc_stack_sequencer.sv
// CALL/RET/INT/RTI sequencer: spills and restores PC (and flags) through a 16-bit stack port.
// Latency accept->pc_load: CALL 3, INT 4, RET 4, RTI 5 cycles.
// Backpressure: stall holds fetch/decode from the accept cycle until the redirect cycle; requests while busy are ignored.
module pc_stack_sequencer
  import pc_stack_sequencer_pkg::*;
#(
  parameter logic [PC_W-1:0] INT_VECTOR = INT_VECTOR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              call_req,
  input  logic              ret_req,
  input  logic              rti_req,
  input  logic              interrupt,
  input  logic [PC_W-1:0]   pc_ret,
  input  logic [PC_W-1:0]   pc_target,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stack_push,
  output logic              stack_pop,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_value,
  output logic              flags_load,
  output logic [FLAG_W-1:0] flags_value,
  output logic              stall,
  output logic              busy
);

  state_t              r_state;
  state_t              w_state_nxt;
  op_t                 r_op;
  op_t                 w_accept_op;
  logic                w_accept_vld;
  logic                w_idle;
  logic [PC_W-1:0]     r_ret;
  logic [PC_W-1:0]     r_target;
  logic [FLAG_W-1:0]   r_flags;
  logic [DATA_W-1:0]   r_lo;
  logic [DATA_W-1:0]   r_hi;
  logic                r_int_pending;
  logic                r_int_en;

  // A live interrupt input is taken directly when nothing is pending yet, saving a cycle.
  always_comb begin
    w_idle       = (r_state == ST_IDLE);
    w_accept_vld = 1'b0;
    w_accept_op  = OP_CALL;
    if (w_idle) begin
      if (rti_req) begin
        w_accept_vld = 1'b1;
        w_accept_op  = OP_RTI;
      end else if (ret_req) begin
        w_accept_vld = 1'b1;
        w_accept_op  = OP_RET;
      end else if (call_req) begin
        w_accept_vld = 1'b1;
        w_accept_op  = OP_CALL;
      end else if (r_int_pending || (interrupt && r_int_en)) begin
        w_accept_vld = 1'b1;
        w_accept_op  = OP_INT;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept_vld) begin
          case (w_accept_op)
            OP_RTI:  w_state_nxt = ST_POP_FLG;
            OP_RET:  w_state_nxt = ST_POP_LO;
            default: w_state_nxt = ST_PUSH_HI;
          endcase
        end
      end
      ST_PUSH_HI:  w_state_nxt = ST_PUSH_LO;
      ST_PUSH_LO:  w_state_nxt = (r_op == OP_INT) ? ST_PUSH_FLG : ST_REDIRECT;
      ST_PUSH_FLG: w_state_nxt = ST_REDIRECT;
      ST_POP_FLG:  w_state_nxt = ST_POP_LO;
      ST_POP_LO:   w_state_nxt = ST_POP_HI;
      ST_POP_HI:   w_state_nxt = ST_WAIT_HI;
      ST_WAIT_HI:  w_state_nxt = ST_REDIRECT;
      ST_REDIRECT: w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    stack_push  = 1'b0;
    stack_pop   = 1'b0;
    mem_wdata   = '0;
    pc_load     = 1'b0;
    pc_value    = '0;
    flags_load  = 1'b0;
    flags_value = '0;
    busy        = !w_idle;
    stall       = !w_idle || w_accept_vld;
    case (r_state)
      ST_PUSH_HI: begin
        stack_push = 1'b1;
        mem_wdata  = r_ret[PC_W-1:DATA_W];
      end
      ST_PUSH_LO: begin
        stack_push = 1'b1;
        mem_wdata  = r_ret[DATA_W-1:0];
      end
      ST_PUSH_FLG: begin
        stack_push = 1'b1;
        mem_wdata  = {{(DATA_W-FLAG_W){1'b0}}, r_flags};
      end
      ST_POP_FLG, ST_POP_LO, ST_POP_HI: begin
        stack_pop = 1'b1;
      end
      ST_REDIRECT: begin
        pc_load = 1'b1;
        case (r_op)
          OP_CALL: pc_value = r_target;
          OP_INT:  pc_value = INT_VECTOR;
          default: pc_value = {r_hi, r_lo};
        endcase
        if (r_op == OP_RTI) begin
          flags_load  = 1'b1;
          flags_value = r_flags;
        end
      end
      default: begin
      end
    endcase
  end

  // Pop data lands one cycle after stack_pop, so each capture trails its pop state by one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_CALL;
      r_ret    <= '0;
      r_target <= '0;
      r_flags  <= '0;
      r_lo     <= '0;
      r_hi     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept_vld) begin
        r_op <= w_accept_op;
        if (w_accept_op == OP_CALL || w_accept_op == OP_INT) begin
          r_ret <= pc_ret;
        end
        if (w_accept_op == OP_CALL) begin
          r_target <= pc_target;
        end
        if (w_accept_op == OP_INT) begin
          r_flags <= flags_in;
        end
      end
      if (r_state == ST_POP_LO && r_op == OP_RTI) begin
        r_flags <= mem_rdata[FLAG_W-1:0];
      end
      if (r_state == ST_POP_HI) begin
        r_lo <= mem_rdata;
      end
      if (r_state == ST_WAIT_HI) begin
        r_hi <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_int_pending <= 1'b0;
      r_int_en      <= 1'b1;
    end else if (w_accept_vld && w_accept_op == OP_INT) begin
      r_int_pending <= 1'b0;
      r_int_en      <= 1'b0;
    end else begin
      if (interrupt && r_int_en) begin
        r_int_pending <= 1'b1;
      end
      if (r_state == ST_REDIRECT && r_op == OP_RTI) begin
        r_int_en <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_stack_sequencer.sv
// Scoreboard bench: a transaction-level model predicts pushes, redirects and stall per cycle; a monitor compares.
module tb_pc_stack_sequencer;

  localparam logic [31:0] TB_VEC = 32'h0000_8000;

  logic        clk;
  logic        reset;
  logic        call_req, ret_req, rti_req, interrupt;
  logic [31:0] pc_ret, pc_target;
  logic [3:0]  flags_in;
  logic [15:0] mem_rdata;
  logic        stack_push, stack_pop, pc_load, flags_load, stall, busy;
  logic [15:0] mem_wdata;
  logic [31:0] pc_value;
  logic [3:0]  flags_value;

  pc_stack_sequencer #(.INT_VECTOR(TB_VEC)) dut (
    .clk(clk), .reset(reset),
    .call_req(call_req), .ret_req(ret_req), .rti_req(rti_req), .interrupt(interrupt),
    .pc_ret(pc_ret), .pc_target(pc_target), .flags_in(flags_in), .mem_rdata(mem_rdata),
    .stack_push(stack_push), .stack_pop(stack_pop), .mem_wdata(mem_wdata),
    .pc_load(pc_load), .pc_value(pc_value), .flags_load(flags_load), .flags_value(flags_value),
    .stall(stall), .busy(busy)
  );

  typedef struct {
    logic [31:0] pc;
    logic        fl_ld;
    logic [3:0]  fl;
    int          due;
  } load_t;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  load_t       exp_load[$];
  logic [15:0] exp_push[$];
  logic [1:0]  exp_cyc[$];
  logic [15:0] push_log[$];

  // Reference model: stack of spilled words, frame kinds (1 = interrupt frame), sequence length countdown.
  logic [15:0] stk[$];
  bit          frames[$];
  int          m_left = 0;
  bit          m_pend = 0;
  bit          m_en = 1;
  bit          m_rti = 0;

  int          load_cnt = 0, pop_cnt = 0, stall_cnt = 0, last_cyc = 0;
  logic [31:0] last_pc = '0;
  logic [3:0]  last_fl = '0;
  logic        last_flld = 1'b0;

  bit [15:0]   mem [256];
  int          sp = 200;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic bad(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: actual=unexpected event required=none", nm);
  endtask

  // Stack memory: push writes at SP then decrements; pop increments then returns data next cycle.
  initial begin
    logic [15:0] nxt;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      nxt = 16'($urandom);
      if (stack_push) begin
        mem[sp[7:0]] = mem_wdata;
        sp--;
      end
      if (stack_pop) begin
        sp++;
        nxt = mem[sp[7:0]];
      end
      @(posedge clk);
      #1;
      mem_rdata = nxt;
    end
  end

  initial begin
    logic [1:0] rec;
    load_t      e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (exp_cyc.size() == 0) bad("no_model_cycle");
        else begin
          rec = exp_cyc.pop_front();
          chk("stall", {31'b0, stall}, {31'b0, rec[1]});
          chk("busy", {31'b0, busy}, {31'b0, rec[0]});
        end
        chk("push_pop_exclusive", {31'b0, stack_push & stack_pop}, 32'd0);
        if (stall) stall_cnt++;
        if (stack_pop) pop_cnt++;
        if (stack_push) begin
          push_log.push_back(mem_wdata);
          if (exp_push.size() == 0) bad("unexpected_push");
          else chk("push_data", {16'b0, mem_wdata}, {16'b0, exp_push.pop_front()});
        end
        if (pc_load) begin
          load_cnt++;
          last_pc = pc_value;
          last_fl = flags_value;
          last_flld = flags_load;
          last_cyc = cyc;
          if (exp_load.size() == 0) bad("unexpected_pc_load");
          else begin
            e = exp_load.pop_front();
            chk("pc_value", pc_value, e.pc);
            chk("flags_load", {31'b0, flags_load}, {31'b0, e.fl_ld});
            if (e.fl_ld) chk("flags_value", {28'b0, flags_value}, {28'b0, e.fl});
            chk("pc_load_cycle", cyc, e.due);
          end
        end else if (flags_load) begin
          bad("flags_load_without_pc_load");
        end
      end
    end
  end

  // One clock cycle of stimulus; entered and left at posedge+1.
  task automatic cycle(input bit c, input bit r, input bit t, input bit i,
                       input logic [31:0] pr, input logic [31:0] pt, input logic [3:0] f);
    bit          idle, take_int, en_cur;
    logic [15:0] lo, hi, fw;
    call_req = c; ret_req = r; rti_req = t; interrupt = i;
    pc_ret = pr; pc_target = pt; flags_in = f;
    idle = (m_left == 0);
    en_cur = m_en;
    take_int = idle && !t && !r && !c && (m_pend || (i && en_cur));
    exp_cyc.push_back({!idle || t || r || c || take_int, !idle});
    if (idle && t) begin
      fw = stk.pop_back(); lo = stk.pop_back(); hi = stk.pop_back();
      void'(frames.pop_back());
      exp_load.push_back('{{hi, lo}, 1'b1, fw[3:0], cyc + 5});
      m_left = 5; m_rti = 1;
    end else if (idle && r) begin
      lo = stk.pop_back(); hi = stk.pop_back();
      void'(frames.pop_back());
      exp_load.push_back('{{hi, lo}, 1'b0, 4'h0, cyc + 4});
      m_left = 4; m_rti = 0;
    end else if (idle && (c || take_int)) begin
      exp_push.push_back(pr[31:16]); exp_push.push_back(pr[15:0]);
      stk.push_back(pr[31:16]); stk.push_back(pr[15:0]);
      if (c) begin
        frames.push_back(1'b0);
        exp_load.push_back('{pt, 1'b0, 4'h0, cyc + 3});
        m_left = 3;
      end else begin
        exp_push.push_back({12'b0, f}); stk.push_back({12'b0, f});
        frames.push_back(1'b1);
        exp_load.push_back('{TB_VEC, 1'b0, 4'h0, cyc + 4});
        m_left = 4;
      end
      m_rti = 0;
    end else if (!idle) begin
      if (m_left == 1 && m_rti) m_en = 1;
      m_left--;
    end
    if (take_int) begin
      m_pend = 0;
      m_en = 0;
    end else if (i && en_cur) begin
      m_pend = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 32'(k * 7 + 3), 32'hDEAD_0000, 4'h0);
  endtask

  initial begin
    int a, s, p, lc;
    bit c, r, t, i, top_call, top_int;
    int k;
    reset = 1'b0;
    call_req = 0; ret_req = 0; rti_req = 0; interrupt = 0;
    pc_ret = '0; pc_target = '0; flags_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_pc_load", {31'b0, pc_load}, 32'd0);
    chk("rst_push", {31'b0, stack_push}, 32'd0);
    reset = 1'b1;

    // CALL right on the first edge after release
    push_log.delete(); a = cyc; s = stall_cnt;
    cycle(1, 0, 0, 0, 32'h0000_1234, 32'h0000_0200, 4'h0);
    idle_n(4);
    chk("call_pc", last_pc, 32'h0000_0200);
    chk("call_latency", last_cyc - a, 3);
    chk("call_stall_cycles", stall_cnt - s, 4);
    chk("call_push_count", push_log.size(), 2);
    chk("call_push0", {16'b0, push_log[0]}, 32'h0000);
    chk("call_push1", {16'b0, push_log[1]}, 32'h1234);

    a = cyc; p = pop_cnt;
    cycle(0, 1, 0, 0, 32'h0, 32'h0, 4'h0);
    idle_n(5);
    chk("ret_pc", last_pc, 32'h0000_1234);
    chk("ret_latency", last_cyc - a, 4);
    chk("ret_pops", pop_cnt - p, 2);

    push_log.delete(); a = cyc;
    cycle(0, 0, 0, 1, 32'h0001_0040, 32'h0, 4'b1010);
    idle_n(5);
    chk("int_pc", last_pc, TB_VEC);
    chk("int_latency", last_cyc - a, 4);
    chk("int_push_count", push_log.size(), 3);
    chk("int_push0", {16'b0, push_log[0]}, 32'h0001);
    chk("int_push1", {16'b0, push_log[1]}, 32'h0040);
    chk("int_push2", {16'b0, push_log[2]}, 32'h000A);
    lc = load_cnt;
    cycle(0, 0, 0, 1, 32'h0, 32'h0, 4'h3);
    idle_n(4);
    chk("nested_int_ignored", load_cnt - lc, 0);

    a = cyc;
    cycle(0, 0, 1, 0, 32'h0, 32'h0, 4'h0);
    idle_n(6);
    chk("rti_pc", last_pc, 32'h0001_0040);
    chk("rti_flags", {28'b0, last_fl}, 32'hA);
    chk("rti_flags_load", {31'b0, last_flld}, 32'd1);
    chk("rti_latency", last_cyc - a, 5);
    lc = load_cnt;
    cycle(0, 0, 0, 1, 32'h0002_0002, 32'h0, 4'h6);
    idle_n(5);
    chk("int_reenabled", load_cnt - lc, 1);
    cycle(0, 0, 1, 0, 32'h0, 32'h0, 4'h0);
    idle_n(6);

    // CALL and interrupt together: CALL first, INT taken in the following IDLE cycle
    a = cyc; lc = load_cnt;
    cycle(1, 0, 0, 1, 32'h0000_5678, 32'h0000_0300, 4'h5);
    idle_n(10);
    chk("simul_loads", load_cnt - lc, 2);
    chk("simul_last_pc", last_pc, TB_VEC);
    chk("simul_int_cycle", last_cyc - a, 8);
    cycle(0, 0, 1, 0, 32'h0, 32'h0, 4'h0);
    idle_n(6);
    cycle(0, 1, 0, 0, 32'h0, 32'h0, 4'h0);
    idle_n(5);

    // Reset in the middle of a CALL spill
    lc = load_cnt;
    cycle(1, 0, 0, 0, 32'h0000_7777, 32'h0000_0400, 4'h0);
    idle_n(1);
    chk("pre_reset_push_lo", {31'b0, stack_push}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_push", {31'b0, stack_push}, 32'd0);
    chk("mid_rst_pop", {31'b0, stack_pop}, 32'd0);
    chk("mid_rst_wdata", {16'b0, mem_wdata}, 32'd0);
    chk("mid_rst_pc_load", {31'b0, pc_load}, 32'd0);
    chk("mid_rst_pc_value", pc_value, 32'd0);
    chk("mid_rst_flags_load", {31'b0, flags_load}, 32'd0);
    chk("mid_rst_flags_value", {28'b0, flags_value}, 32'd0);
    chk("mid_rst_stall", {31'b0, stall}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    exp_load.delete(); exp_push.delete(); exp_cyc.delete();
    stk.delete(); frames.delete();
    m_left = 0; m_pend = 0; m_en = 1; m_rti = 0;
    sp = 200;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle_n(5);
    chk("post_rst_no_load", load_cnt - lc, 0);

    // Randomised phase; junk requests are driven while busy
    for (int n = 0; n < 700; n++) begin
      c = 0; r = 0; t = 0;
      i = ($urandom_range(0, 11) == 0);
      if (m_left != 0) begin
        c = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) == 0);
        t = ($urandom_range(0, 3) == 0);
      end else begin
        top_call = (frames.size() > 0) && !frames[frames.size() - 1];
        top_int  = (frames.size() > 0) && frames[frames.size() - 1];
        k = $urandom_range(0, 9);
        if (k < 3 && frames.size() < 16) c = 1;
        else if (k < 6 && top_call) begin
          r = 1; c = 1'($urandom_range(0, 1));
        end else if (k < 8 && top_int) begin
          t = 1; r = 1'($urandom_range(0, 1)); c = 1'($urandom_range(0, 1));
        end
      end
      cycle(c, r, t, i, $urandom, $urandom, 4'($urandom));
    end
    for (int n = 0; n < 40 && (m_left != 0 || m_pend); n++) cycle(0, 0, 0, 0, $urandom, $urandom, 4'($urandom));
    if (m_left != 0 || m_pend) bad("drain_timeout");
    idle_n(3);
    chk("left_exp_loads", exp_load.size(), 0);
    chk("left_exp_pushes", exp_push.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
